// File: rtl/binary_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : binary_game_ctrl
// Brief   : Round sequencer for the binary-conversion game (timer pacing,
//           target draw, judging and scoring).
// Rev     : 1.0
// ============================================================================
module binary_game_ctrl #(
  parameter int         WIDTH     = 8,
  parameter int         TICK_DIV  = 100000000,
  parameter int         SCORE_W   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         FLASH_CYC = 50000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               submit,
  input  logic [WIDTH-1:0]   guess,
  input  logic               game_end,
  output logic               timer_clr,
  output logic               tick,
  output logic [WIDTH-1:0]   target,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               correct,
  output logic               wrong
);

  localparam int c_div_w   = $clog2(TICK_DIV);
  localparam int c_flash_w = $clog2(FLASH_CYC + 1);
  localparam logic [c_div_w-1:0]   c_div_last  = c_div_w'(TICK_DIV - 1);
  localparam logic [c_div_w-1:0]   c_div_pen   = c_div_w'(TICK_DIV - 2);
  localparam logic [c_flash_w-1:0] c_flash_ld  = c_flash_w'(FLASH_CYC - 1);
  localparam logic [SCORE_W-1:0]   c_score_max = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_JUDGE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_lfsr;
  logic [c_div_w-1:0]   r_div;
  logic [c_flash_w-1:0] r_flash;
  logic [WIDTH-1:0]     r_target, r_guess_q;
  logic [SCORE_W-1:0]   r_score;
  logic                 r_tick, r_timer_clr, r_correct, r_wrong;

  logic             w_fb, w_launch, w_match;
  logic [WIDTH-1:0] w_rand;

  assign w_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_rand   = WIDTH'(r_lfsr);
  assign w_launch = ((r_state == S_IDLE) || (r_state == S_OVER)) && start;
  assign w_match  = (r_guess_q == r_target);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // game_end outranks a simultaneous submit so the last press cannot score late
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (game_end)    w_state_nxt = S_OVER;
        else if (submit) w_state_nxt = S_JUDGE;
      end
      S_JUDGE: w_state_nxt = game_end ? S_OVER : S_PLAY;
      S_OVER:  if (start) w_state_nxt = S_PLAY;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr      <= LFSR_SEED;
      r_div       <= '0;
      r_tick      <= 1'b0;
      r_timer_clr <= 1'b0;
      r_score     <= '0;
      r_target    <= '0;
      r_guess_q   <= '0;
      r_flash     <= '0;
      r_correct   <= 1'b0;
      r_wrong     <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[6:0], w_fb};
      r_timer_clr <= w_launch;
      r_tick      <= 1'b0;

      if (w_launch) begin
        r_score  <= '0;
        r_target <= w_rand;
        r_div    <= '0;
      end else if ((r_state == S_PLAY) || (r_state == S_JUDGE)) begin
        r_div  <= (r_div == c_div_last) ? '0 : r_div + c_div_w'(1);
        r_tick <= (w_state_nxt != S_OVER) && (r_div == c_div_pen);
      end

      if ((r_state == S_PLAY) && submit && !game_end)
        r_guess_q <= guess;

      // One shared counter times whichever indicator the latest judgment set
      if (r_state == S_JUDGE) begin
        r_flash   <= c_flash_ld;
        r_correct <= w_match;
        r_wrong   <= !w_match;
        if (w_match) begin
          if (r_score != c_score_max) r_score <= r_score + SCORE_W'(1);
          r_target <= (w_rand == r_target) ? (w_rand ^ WIDTH'(1)) : w_rand;
        end
      end else if (r_flash != '0) begin
        r_flash <= r_flash - c_flash_w'(1);
      end else begin
        r_correct <= 1'b0;
        r_wrong   <= 1'b0;
      end
    end
  end

  assign timer_clr = r_timer_clr;
  assign tick      = r_tick;
  assign target    = r_target;
  assign score     = r_score;
  assign state     = r_state;
  assign correct   = r_correct;
  assign wrong     = r_wrong;

endmodule
`default_nettype wire
